// File: rtl/pulsegen_div_pkg.sv
// Shared constants, state encoding and divisor clamp for the pulsegen_div block.
// The optional sync restart input is enabled by PULSEGEN_DIV_SYNC_EN.
package pulsegen_div_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Divisors of 0 or 1 cannot produce a period with both phases, so they become 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/pulsegen_div_shadow.sv
// Active/shadow divisor and mode registers: loads go straight to the active copy
// when idle or on a period boundary, otherwise they wait in the shadow.
module pulsegen_div_shadow
    import pulsegen_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             run,
    input  logic             boundary,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    output logic [WIDTH-1:0] div_act,
    output logic             mode_act,
    output logic             pending
);

    logic [WIDTH-1:0] div_clamped;
    logic [WIDTH-1:0] div_act_reg;
    logic             mode_act_reg;
    logic [WIDTH-1:0] shadow_div_reg;
    logic             shadow_mode_reg;
    logic             pending_reg;

    assign div_clamped = WIDTH'(clamp_div(32'(div_in)));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            div_act_reg     <= WIDTH'(DEFAULT_DIV);
            mode_act_reg    <= MODE_SQUARE;
            shadow_div_reg  <= WIDTH'(DEFAULT_DIV);
            shadow_mode_reg <= MODE_SQUARE;
            pending_reg     <= 1'b0;
        end else if (!run) begin
            if (div_load) begin
                div_act_reg  <= div_clamped;
                mode_act_reg <= mode_in;
            end
        end else if (boundary) begin
            // A load coinciding with the boundary wins over an older pending value.
            if (div_load) begin
                div_act_reg  <= div_clamped;
                mode_act_reg <= mode_in;
            end else if (pending_reg) begin
                div_act_reg  <= shadow_div_reg;
                mode_act_reg <= shadow_mode_reg;
            end
            pending_reg <= 1'b0;
        end else if (div_load) begin
            shadow_div_reg  <= div_clamped;
            shadow_mode_reg <= mode_in;
            pending_reg     <= 1'b1;
        end
    end

    assign div_act  = div_act_reg;
    assign mode_act = mode_act_reg;
    assign pending  = pending_reg;

endmodule

// File: rtl/pulsegen_div.sv
// Runtime-programmable clock divider / pulse generator with glitch-free ratio changes.
// Define PULSEGEN_DIV_SYNC_EN to add the sync restart input.
module pulsegen_div
    import pulsegen_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    output logic             clkout,
    output logic             tick,
    output logic             running,
    output logic             pending
`ifdef PULSEGEN_DIV_SYNC_EN
    ,
    input  logic             sync
`endif
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] p_reg, p_next;
    logic             clkout_reg, clkout_next;
    logic             tick_reg, tick_next;
    logic [WIDTH-1:0] div_act;
    logic             mode_act;
    logic             boundary;
    logic             sync_hit;
    logic             wrap;
    logic [WIDTH:0]   half;
    logic [WIDTH:0]   p_inc;

`ifdef PULSEGEN_DIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    // Computed one bit wider so ratios near 2^WIDTH cannot overflow.
    assign half  = ({1'b0, div_act} + ONE_W) >> 1;
    assign p_inc = {1'b0, p_reg} + ONE_W;
    assign wrap  = (p_reg == div_act - ONE);

    pulsegen_div_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk      (clk),
        .nrst     (nrst),
        .run      (state_reg == ST_RUN),
        .boundary (boundary),
        .div_load (div_load),
        .div_in   (div_in),
        .mode_in  (mode_in),
        .div_act  (div_act),
        .mode_act (mode_act),
        .pending  (pending)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg  <= ST_IDLE;
            p_reg      <= '0;
            clkout_reg <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            p_reg      <= p_next;
            clkout_reg <= clkout_next;
            tick_reg   <= tick_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        p_next      = '0;
        clkout_next = 1'b0;
        tick_next   = 1'b0;
        boundary    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    state_next  = ST_RUN;
                    clkout_next = 1'b1;
                    tick_next   = 1'b1;
                end
            end
            ST_RUN: begin
                if (sync_hit) begin
                    boundary    = 1'b1;
                    clkout_next = 1'b1;
                    tick_next   = 1'b1;
                end else if (wrap) begin
                    // en is only honoured here, so a period is never cut short.
                    boundary = 1'b1;
                    if (en) begin
                        clkout_next = 1'b1;
                        tick_next   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    p_next      = p_inc[WIDTH-1:0];
                    clkout_next = (mode_act == MODE_SQUARE) && (p_inc < half);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign clkout  = clkout_reg;
    assign tick    = tick_reg;
    assign running = (state_reg == ST_RUN);

endmodule

// File: tb/tb_pulsegen_div.sv
// Directed and randomized checks of pulsegen_div against a period-position reference model.
// Exercises the sync input as well when PULSEGEN_DIV_SYNC_EN is defined.
module tb_pulsegen_div;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             mode_in = 1'b0;
    logic             sync = 1'b0;
    logic             clkout, tick, running, pending;

    int checks = 0;
    int errors = 0;

    // Reference model: whether a period is in progress, position within it, active/pending settings.
    bit m_run, m_mode, m_pend, m_sh_mode;
    int m_pos, m_r, m_sh_r;

    pulsegen_div #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .div_load (div_load),
        .div_in   (div_in),
        .mode_in  (mode_in),
        .clkout   (clkout),
        .tick     (tick),
        .running  (running),
        .pending  (pending)
`ifdef PULSEGEN_DIV_SYNC_EN
        ,
        .sync     (sync)
`endif
    );

    always #5 clk = ~clk;

    function automatic int clampm(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit sy;
        sy = (sync === 1'b1);
        if (!nrst) begin
            m_run = 0; m_pos = 0; m_r = DEFAULT_DIV; m_mode = 0;
            m_sh_r = DEFAULT_DIV; m_sh_mode = 0; m_pend = 0;
        end else if (!m_run) begin
            if (div_load) begin
                m_r = clampm(int'(div_in)); m_mode = mode_in;
            end
            if (en) begin
                m_run = 1; m_pos = 0;
            end
        end else if (sy || m_pos == m_r - 1) begin
            if (div_load) begin
                m_r = clampm(int'(div_in)); m_mode = mode_in; m_pend = 0;
            end else if (m_pend) begin
                m_r = m_sh_r; m_mode = m_sh_mode; m_pend = 0;
            end
            m_pos = 0;
            if (!sy && !en) m_run = 0;
        end else begin
            m_pos++;
            if (div_load) begin
                m_sh_r = clampm(int'(div_in)); m_sh_mode = mode_in; m_pend = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic e_clk, e_tick;
        e_tick = m_run && (m_pos == 0);
        e_clk  = m_run && (m_mode ? (m_pos == 0) : (m_pos < (m_r + 1) / 2));
        check({tag, "_clkout"}, clkout, e_clk);
        check({tag, "_tick"}, tick, e_tick);
        check({tag, "_running"}, running, logic'(m_run));
        check({tag, "_pending"}, pending, logic'(m_pend));
        $display("%s t=%0t nrst=%b en=%b ld=%b div=%0d mode=%b sync=%b -> clkout=%b tick=%b running=%b pending=%b",
                 tag, $time, nrst, en, div_load, div_in, mode_in, sync, clkout, tick, running, pending);
    endtask

    task automatic cyc(input string tag, input logic e, input logic l, input int d, input logic m);
        en = e; div_load = l; div_in = WIDTH'(d); mode_in = m;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600 && running; i++) cyc(tag, 0, 0, 0, 0);
        check({tag, "_idle_reached"}, running, 1'b0);
    endtask

    initial begin
        // Reset
        nrst = 1'b0;
        cyc("reset", 1, 1, 9, 1);
        cyc("reset", 0, 0, 0, 0);
        nrst = 1'b1;
        cyc("idle", 0, 0, 0, 0);

        // 1: default ratio 2
        for (int i = 0; i < 8; i++) cyc("t1", 1, 0, 0, 0);

        // 2: ratio 5 loaded in IDLE, then ratio 0 clamped to 2
        drain("t2");
        cyc("t2_load5", 1, 1, 5, 0);
        for (int i = 0; i < 12; i++) cyc("t2", 1, 0, 0, 0);
        drain("t2");
        cyc("t2_load0", 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc("t2", 1, 0, 0, 0);

        // 3: mid-period load of 3/pulse waits for the wrap
        drain("t3");
        cyc("t3_load5", 1, 1, 5, 0);
        cyc("t3", 1, 0, 0, 0);
        cyc("t3_load3", 1, 1, 3, 1);
        check("t3_pending_set", pending, 1'b1);
        for (int i = 0; i < 10; i++) cyc("t3", 1, 0, 0, 0);
        check("t3_pending_clear", pending, 1'b0);

        // 4: en dropped at p=0 of R=4 finishes the period
        drain("t4");
        cyc("t4_load4", 1, 1, 4, 0);
        for (int i = 0; i < 6; i++) cyc("t4_off", 0, 0, 0, 0);
        check("t4_idle", running, 1'b0);
        for (int i = 0; i < 3; i++) cyc("t4_on", 1, 0, 0, 0);

        // 5: reset mid high phase, then back-to-back loads
        drain("t5");
        cyc("t5_load6", 1, 1, 6, 0);
        cyc("t5", 1, 0, 0, 0);
        nrst = 1'b0;
        cyc("t5_rst", 1, 0, 0, 0);
        check("t5_rst_clkout", clkout, 1'b0);
        nrst = 1'b1;
        cyc("t5", 1, 0, 0, 0);
        cyc("t5_load7", 1, 1, 7, 0);
        cyc("t5_load9", 1, 1, 9, 0);
        for (int i = 0; i < 25; i++) cyc("t5", 1, 0, 0, 0);

`ifdef PULSEGEN_DIV_SYNC_EN
        // 6: sync restart at p=2 of R=8
        drain("t6");
        cyc("t6_load8", 1, 1, 8, 0);
        cyc("t6", 1, 0, 0, 0);
        cyc("t6", 1, 0, 0, 0);
        sync = 1'b1;
        cyc("t6_sync", 1, 0, 0, 0);
        sync = 1'b0;
        check("t6_sync_tick", tick, 1'b1);
        check("t6_sync_clkout", clkout, 1'b1);
        for (int i = 0; i < 10; i++) cyc("t6", 1, 0, 0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            nrst = ($urandom_range(0, 199) != 0);
`ifdef PULSEGEN_DIV_SYNC_EN
            sync = ($urandom_range(0, 49) == 0);
`endif
            cyc("rnd", ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), d, logic'($urandom_range(0, 1)));
        end
        sync = 1'b0;
        nrst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulsegen_div.md
Name: pulsegen_div

Overview:
- Parametrised, runtime-programmable clock divider and pulse generator for the NAND-era system clocking.
- Replaces the fixed divide-by-2 latch divider.
- Produces a divided clock with a divide ratio R selected at runtime, in one of two modes:
  - square mode: near-50% duty;
  - pulse mode: one high cycle per period.
- Also produces a one-cycle tick at each period start.
- Ratio and mode updates apply only at period boundaries, so no runt pulses occur. Enable/disable is also glitch-free.

Parameters:
- WIDTH, 8, width of the divisor field.
- DEFAULT_DIV, 2, ratio loaded at reset. Must be >= 2 and < 2^WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nrst  in  1  reset, synchronous, active-low.
- en  in  1  run request.
- div_load  in  1  load strobe for div_in and mode_in.
- div_in  in  WIDTH  requested divisor.
- mode_in  in  1  0 = square, 1 = pulse.
- clkout  out  1  divided clock (registered).
- tick  out  1  one-cycle pulse at the start of each period (registered).
- running  out  1  high in the RUN state.
- pending  out  1  a loaded divisor/mode is waiting for a boundary.

Behaviour:
- Reset (edge with nrst=0), applied regardless of other inputs:
  - state = IDLE, p = 0;
  - R_act = DEFAULT_DIV, mode_act = square;
  - shadow = DEFAULT_DIV / square;
  - clkout = 0, tick = 0, running = 0, pending = 0.
  - Reset mid-period truncates the output immediately. This is the only permitted truncation.
- Clamp: any divisor < 2 (0 or 1) is stored as 2. Ratio arithmetic is unsigned on WIDTH bits.
- Definitions: H = ceil(R_act/2). Phase counter p runs 0..R_act-1.
- IDLE state:
  - p = 0, clkout = 0, tick = 0.
  - On an edge with en=1: go to RUN, p<=0, clkout<=1, tick<=1, running<=1.
  - Latency from en to clkout rising is 1 cycle.
- RUN state, edge with p < R_act-1:
  - p<=p+1, tick<=0.
  - Square mode: clkout <= (p+1 < H).
  - Pulse mode: clkout <= 0.
- RUN state, edge with p = R_act-1 (wrap):
  - If pending, first apply the shadow to R_act/mode_act and clear pending.
  - If en=1: p<=0, clkout<=1, tick<=1.
  - If en=0: go to IDLE, clkout<=0, running<=0.
  - Effect: deasserting en always completes the current period.
- Output timing:
  - Square mode: high for ceil(R/2) cycles, low for floor(R/2). R=3 gives 2 high / 1 low.
  - Pulse mode: clkout equals tick.
- div_load=1 (RUN): shadow<=clamp(div_in), mode_in; pending<=1.
  - Back-to-back loads: last one wins.
- div_load=1 on a wrap edge: the loaded value bypasses the shadow, takes effect for the period starting at that edge, and pending stays 0.
- div_load=1 in IDLE: applied directly to R_act/mode_act; pending stays 0.
- en toggling mid-period has no effect until the wrap.

Optional Feature:
- Macro: PULSEGEN_DIV_SYNC_EN.
- With the macro defined:
  - Adds input port sync (1 bit).
  - sync=1 in RUN forces a restart: pending shadow applied, p<=0, clkout<=1, tick<=1.
  - This is used to phase-align multiple dividers.
  - The high phase may lengthen but is never shortened.
  - sync in IDLE is ignored.
  - Precedence: nrst > sync > wrap logic.
- Without the macro: no port, and the behaviour above is unchanged.

Decomposition:
- Package pulsegen_div_pkg holds:
  - mode constants MODE_SQUARE=1'b0, MODE_PULSE=1'b1;
  - state encoding ST_IDLE / ST_RUN;
  - MIN_DIV=2;
  - a clamp function.
- Sub-module pulsegen_div_shadow (WIDTH) holds the shadow register, pending flag and wrap/idle bypass logic.
- The top level holds the FSM, phase counter and output registers.

Test Plan:
1. Reset, then en=1 with DEFAULT_DIV=2 -> clkout 0,1,0,1… starting the cycle after en; tick high in every cycle where clkout rises; running=1.
2. IDLE load div_in=5, square, en=1 -> clkout 1,1,1,0,0 repeating; tick once per 5 cycles. Load 0 -> behaves as R=2.
3. While running R=5, load div_in=3 with mode_in=1 at p=1 -> pending=1 until the wrap; next period is 3 cycles with a single-cycle high; pending clears on the wrap edge.
4. Drop en at p=0 of R=4 -> clkout completes 1,1,0,0, then stays 0 in IDLE; running falls at the wrap; re-assert en -> clkout high the next cycle.
5. Assert nrst=0 during the high phase of R=6 -> clkout=0, R_act=2, pending=0 on the same edge; two loads in consecutive cycles (7 then 9) -> only 9 is applied.
6. (PULSEGEN_DIV_SYNC_EN) R=8, sync pulse at p=2 -> next edge clkout=1, tick=1, p=0; two instances with different start times are phase-aligned after a common sync.
